control_sequencer_ls: RTL and testbench
=======================================

// Module: control_sequencer_ls
// PURPOSE
//  Hardwired control unit that sits directly upstream of DataPath and drives its control inputs.
//  Runs the instruction fetch (T0-T2), decodes IR[31:27] and sequences ld, ldi and st (T3-T7).
//  Handles halt and unsupported opcodes.
//  Memory wait cycles are counted internally, so DataPath and memory need no handshake.
// PARAMETERS
//  MEM_LAT   1        cycles each memory access (Read or Write) is held; legal 1..15
//  OP_LD     5'b00000 ld opcode
//  OP_LDI    5'b00001 ldi opcode
//  OP_ST     5'b00010 st opcode
//  OP_HALT   5'b11011 halt opcode
//  ALU_ADD   5'b00011 ALU select for address add
// PORTS
//  clock     in   1   system clock, all state changes on rising edge
//  clear     in   1   synchronous active-high reset
//  start     in   1   leave IDLE and begin fetching
//  IR        in   32  instruction register contents from DataPath; opcode = IR[31:27]
//  PCout, Zlowout, MDRout, Rout, Cout, BAout   out 1 each  bus-drive enables
//  MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin  out 1 each  register load enables
//  IncPC, Read, Write, Gra, Grb, Grc           out 1 each  PC increment, memory strobes, reg-select
//  opcode    out  5   ALU operation select (ALU_ADD in T0 and T4, else 0)
//  run       out  1   1 in every state except IDLE and HALT
//  state_dbg out  4   current state encoding, for the bench only
// BEHAVIOUR
//  - Moore FSM. Outputs are decoded from the state register only, so they change only after a rising edge.
//  - Reset: clear=1 at a rising edge gives state=IDLE, wait counter=0 and every output 0.
//    clear has priority over start and over any state, including a state mid-wait.
//  - States and encodings: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALT=9.
//  - IDLE (no outputs): goes to T0 when start=1, else stays.
//  - T0: PCout MARin IncPC ZLowIn, opcode=ALU_ADD. Goes to T1.
//  - T1: Zlowout PCin Read MDRin. Held MEM_LAT cycles, then T2.
//  - T2: MDRout IRin. Goes to T3.
//  - T3: decode on the IR value latched in T2.
//    - ld/ldi/st: Grb BAout Yin.
//    - OP_HALT: no outputs, goes to HALT.
//    - any other opcode: no outputs, goes to T0 (NOP).
//  - T4: Cout ZLowIn, opcode=ALU_ADD.
//  - T5: Zlowout, plus:
//    - ld, st: MARin, then T6.
//    - ldi: Gra Rin, then T0.
//  - T6:
//    - ld: Read MDRin, held MEM_LAT cycles.
//    - st: Gra Rout MDRin for 1 cycle; Read=0 so MDR loads from the bus.
//  - T7:
//    - ld: MDRout Gra Rin for 1 cycle.
//    - st: Write, held MEM_LAT cycles.
//  - T7 goes to T0. Execution is continuous; start is ignored outside IDLE.
//  - Wait counter (4 bits):
//    - loads MEM_LAT-1 on entry to T1, ld-T6 and st-T7;
//    - decrements each cycle; the state advances when the count is 0;
//    - Read/Write and the paired enables stay steady for the whole access;
//    - MEM_LAT=1 means no extra cycles.
//  - HALT: all outputs 0, run=0. Left only via clear.
//  - Grc is never asserted by these instructions (driven 0).
//    At most one bus-drive enable is 1 in any cycle.
//  - Instruction length in cycles, wait = MEM_LAT-1:
//    - ld = 8 + 2*wait
//    - ldi = 6 + wait
//    - st = 8 + 2*wait
// TESTING
//  1. MEM_LAT=1, clear for 2 cycles -> all outputs 0 and state_dbg=0. Then start=1 for 1 cycle -> T0 outputs on the next cycle.
//  2. IR=32'h00900054 (ld R1,0x54(R2)) -> exact per-cycle outputs T0..T7 as above over 8 cycles. Rin+Gra+MDRout in cycle 8, then back in T0.
//  3. IR=32'h08900054 (ldi) -> 6 cycles. Gra+Rin+Zlowout in T5, no Read after T1, then T0.
//  4. IR=32'h10900054 (st), MEM_LAT=3 -> Read high 3 cycles in T1, Rout+MDRin 1 cycle in T6, Write high 3 cycles in T7, 12 cycles total.
//  5. IR=32'hD8000000 -> HALT after T3, run=0, outputs frozen at 0 for 20 cycles. clear -> IDLE.
//  6. clear=1 during the 2nd Read cycle of ld-T6 (MEM_LAT=3) -> next cycle IDLE, Read=0, and no Write/Rin ever pulses.

Source files
------------

// File: rtl/control_sequencer_ls.sv
// Hardwired control sequencer for the DataPath: instruction fetch (T0-T2),
// decode of IR[31:27] in T3, and execution of ld, ldi and st (T4-T7).
// Memory accesses are timed by an internal wait counter, so no handshake is needed.
//
// Ports:
//   clock, clear (sync active-high reset), start (leave IDLE)
//   IR         instruction register contents, opcode = IR[31:27]
//   PCout, Zlowout, MDRout, Rout, Cout, BAout   bus-drive enables
//   MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin  register load enables
//   IncPC, Read, Write, Gra, Grb, Grc           PC increment, memory strobes, reg select
//   opcode     ALU operation select
//   run        high in every state except IDLE and HALT
//   state_dbg  current state encoding
module control_sequencer_ls #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [4:0]  OP_LD   = 5'b00000,
  parameter logic [4:0]  OP_LDI  = 5'b00001,
  parameter logic [4:0]  OP_ST   = 5'b00010,
  parameter logic [4:0]  OP_HALT = 5'b11011,
  parameter logic [4:0]  ALU_ADD = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        Rin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  opcode,
  output logic        run,
  output logic [3:0]  state_dbg
);

  localparam int unsigned WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [4:0]        op_q, op_d;

  logic [4:0] ir_op;
  logic       ir_mem;
  logic       is_ld, is_ldi, is_st;
  logic       unused_ir;

  assign ir_op     = IR[31:27];
  assign ir_mem    = (ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST);
  assign unused_ir = ^IR[26:0];

  // Opcode captured when leaving T3 selects the execute path in T5-T7.
  assign is_ld  = (op_q == OP_LD);
  assign is_ldi = (op_q == OP_LDI);
  assign is_st  = (op_q == OP_ST);

  // State, wait counter and captured opcode registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the wait counter is loaded on entry to each memory access state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = WAIT_INIT;
      end
      S_T1: begin
        if (wait_q == '0) state_d = S_T2;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        op_d = ir_op;
        if (ir_mem)                state_d = S_T4;
        else if (ir_op == OP_HALT) state_d = S_HALT;
        else                       state_d = S_T0;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_ld) begin
          state_d = S_T6;
          wait_d  = WAIT_INIT;
        end else if (is_st) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          if (wait_q == '0) state_d = S_T7;
          else              wait_d  = wait_q - WAIT_W'(1);
        end else begin
          state_d = S_T7;
          wait_d  = WAIT_INIT;
        end
      end
      S_T7: begin
        if (is_st && (wait_q != '0)) wait_d  = wait_q - WAIT_W'(1);
        else                         state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; T3 looks at IR directly since it was loaded on entry to T3.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Rout    = 1'b0;
    Cout    = 1'b0;
    BAout   = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    ZLowIn  = 1'b0;
    Rin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    opcode  = 5'd0;
    run     = (state_q != S_IDLE) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
        opcode = ALU_ADD;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (ir_mem) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end
      end
      S_T4: begin
        Cout   = 1'b1;
        ZLowIn = 1'b1;
        opcode = ALU_ADD;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ldi) begin
          Gra = 1'b1;
          Rin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_ld) begin
          Read = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_sequencer_ls.sv
// Bench for control_sequencer_ls: two instances (MEM_LAT=1 and MEM_LAT=3),
// expected per-cycle output bundles queued per instruction and compared each cycle.
module tb_control_sequencer_ls;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  clear_a;
  logic [1:0]  start_a;
  logic [31:0] ir_a [2];
  logic [28:0] obs [2];

  logic [1:0] pcout, zlowout, mdrout, rout, cout, baout, marin, pcin, mdrin, irin;
  logic [1:0] yin, zlowin, rin, incpc, rd, wr, gra, grb, grc, run;
  logic [4:0] opc [2];
  logic [3:0] sdbg [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_sequencer_ls #(.MEM_LAT((g == 0) ? 1 : 3)) dut (
      .clock(clock), .clear(clear_a[g]), .start(start_a[g]), .IR(ir_a[g]),
      .PCout(pcout[g]), .Zlowout(zlowout[g]), .MDRout(mdrout[g]), .Rout(rout[g]),
      .Cout(cout[g]), .BAout(baout[g]), .MARin(marin[g]), .PCin(pcin[g]),
      .MDRin(mdrin[g]), .IRin(irin[g]), .Yin(yin[g]), .ZLowIn(zlowin[g]),
      .Rin(rin[g]), .IncPC(incpc[g]), .Read(rd[g]), .Write(wr[g]),
      .Gra(gra[g]), .Grb(grb[g]), .Grc(grc[g]), .opcode(opc[g]),
      .run(run[g]), .state_dbg(sdbg[g])
    );
    assign obs[g] = {pcout[g], zlowout[g], mdrout[g], rout[g], cout[g], baout[g],
                     marin[g], pcin[g], mdrin[g], irin[g], yin[g], zlowin[g], rin[g],
                     incpc[g], rd[g], wr[g], gra[g], grb[g], grc[g], run[g],
                     opc[g], sdbg[g]};
  end

  typedef struct {
    int          w;
    logic [28:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_HALT = 3, K_NOP = 4;

  // Expected bundle for a state (0..9) while executing instruction kind k.
  function automatic logic [28:0] ex(input int st, input int k);
    logic [28:0] v;
    v = '0;
    v[3:0] = 4'(st);
    if (st != 0 && st != 9) v[9] = 1'b1;
    case (st)
      1: begin v[28] = 1'b1; v[22] = 1'b1; v[15] = 1'b1; v[17] = 1'b1; v[8:4] = 5'b00011; end
      2: begin v[27] = 1'b1; v[21] = 1'b1; v[14] = 1'b1; v[20] = 1'b1; end
      3: begin v[26] = 1'b1; v[19] = 1'b1; end
      4: if (k <= K_ST) begin v[11] = 1'b1; v[23] = 1'b1; v[18] = 1'b1; end
      5: begin v[24] = 1'b1; v[17] = 1'b1; v[8:4] = 5'b00011; end
      6: begin
        v[27] = 1'b1;
        if (k == K_LDI) begin v[12] = 1'b1; v[16] = 1'b1; end
        else v[22] = 1'b1;
      end
      7: if (k == K_LD) begin v[14] = 1'b1; v[20] = 1'b1; end
         else begin v[12] = 1'b1; v[25] = 1'b1; v[20] = 1'b1; end
      8: if (k == K_LD) begin v[26] = 1'b1; v[12] = 1'b1; v[16] = 1'b1; end
         else v[13] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic pu(input int w, input int st, input int k);
    exp_t e;
    e.w = w;
    e.v = ex(st, k);
    exp_q.push_back(e);
  endtask

  // Queue the expected cycles of one instruction starting at T0.
  task automatic push_instr(input int w, input int k, input int lat);
    pu(w, 1, k);
    repeat (lat) pu(w, 2, k);
    pu(w, 3, k);
    pu(w, 4, k);
    case (k)
      K_LD:   begin pu(w, 5, k); pu(w, 6, k); repeat (lat) pu(w, 7, k); pu(w, 8, k); end
      K_LDI:  begin pu(w, 5, k); pu(w, 6, k); end
      K_ST:   begin pu(w, 5, k); pu(w, 6, k); pu(w, 7, k); repeat (lat) pu(w, 8, k); end
      K_HALT: repeat (20) pu(w, 9, k);
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle per queued entry; start is released after the first edge.
  task automatic drain(input string name);
    exp_t e;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      step();
      start_a = 2'b00;
      e = exp_q.pop_front();
      tests_run++;
      if (obs[e.w] !== e.v) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, idx, obs[e.w], e.v);
      end
      idx++;
    end
  endtask

  // Clear one instance for a cycle, then arm a start pulse with the given IR.
  task automatic restart(input int w, input logic [31:0] ir, input string name);
    ir_a[w] = ir;
    clear_a[w] = 1'b1;
    step();
    pu(w, 0, K_NOP);
    clear_a[w] = 1'b0;
    drain({name, "_idle"});
    start_a[w] = 1'b1;
  endtask

  task automatic test_reset();
    clear_a = 2'b11;
    start_a = 2'b11;
    ir_a[0] = 32'h0;
    ir_a[1] = 32'h0;
    pu(0, 0, K_NOP);
    pu(0, 0, K_NOP);
    drain("reset");
    clear_a = 2'b00;
    start_a[0] = 1'b1;
    pu(0, 1, K_NOP);
    drain("start_t0");
  endtask

  task automatic test_ld();
    restart(0, 32'h00900054, "ld");
    push_instr(0, K_LD, 1);
    pu(0, 1, K_NOP);
    drain("ld");
  endtask

  task automatic test_ldi();
    restart(0, 32'h08900054, "ldi");
    push_instr(0, K_LDI, 1);
    pu(0, 1, K_NOP);
    drain("ldi");
  endtask

  task automatic test_st_lat3();
    restart(1, 32'h10900054, "st3");
    push_instr(1, K_ST, 3);
    pu(1, 1, K_NOP);
    drain("st3");
  endtask

  task automatic test_nop();
    restart(0, 32'h18000000, "nop");
    push_instr(0, K_NOP, 1);
    pu(0, 1, K_NOP);
    drain("nop");
  endtask

  task automatic test_back_to_back();
    restart(1, 32'h08900054, "b2b");
    push_instr(1, K_LDI, 3);
    push_instr(1, K_LDI, 3);
    push_instr(1, K_LDI, 3);
    pu(1, 1, K_NOP);
    drain("b2b_ldi");
  endtask

  task automatic test_halt();
    restart(0, 32'hD8000000, "halt");
    push_instr(0, K_HALT, 1);
    drain("halt");
    clear_a[0] = 1'b1;
    pu(0, 0, K_NOP);
    drain("halt_clear");
    clear_a[0] = 1'b0;
  endtask

  task automatic test_clear_mid_wait();
    restart(1, 32'h00900054, "midclr");
    pu(1, 1, K_LD);
    repeat (3) pu(1, 2, K_LD);
    pu(1, 3, K_LD);
    pu(1, 4, K_LD);
    pu(1, 5, K_LD);
    pu(1, 6, K_LD);
    pu(1, 7, K_LD);
    pu(1, 7, K_LD);
    drain("midclr_run");
    clear_a[1] = 1'b1;
    pu(1, 0, K_NOP);
    drain("midclr_clear");
    clear_a[1] = 1'b0;
    repeat (6) pu(1, 0, K_NOP);
    drain("midclr_idle");
  endtask

  initial begin
    test_reset();
    test_ld();
    test_ldi();
    test_st_lat3();
    test_nop();
    test_back_to_back();
    test_halt();
    test_clear_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
